s2p: RTL and testbench



---
 rtl/owp_pkg.sv | 17 +
 rtl/crc8_maxim.sv | 42 ++++
 rtl/s2p.sv | 130 +++++++++++++
 tb/tb_s2p.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/owp_pkg.sv
// Shared definitions for the 1-wire master datapath.
//   CRC8_POLY_REFL  : reflected Dallas/Maxim CRC-8 polynomial (x^8+x^5+x^4+1)
//   BIT_SLOT_CYCLES : clk cycles per bus bit slot, shared with the serializer
//   ROM_ID_WIDTH    : bits in a 1-wire ROM ID
//   s2p_state_t     : receiver FSM states
package owp_pkg;

    localparam logic [7:0]  CRC8_POLY_REFL  = 8'h8C;
    localparam int unsigned BIT_SLOT_CYCLES = 71;
    localparam int unsigned ROM_ID_WIDTH    = 64;

    typedef enum logic [0:0] {
        IDLE,
        RECEIVE
    } s2p_state_t;

endpackage

// File: rtl/crc8_maxim.sv
// Bitwise serial Dallas/Maxim CRC-8, one bit per enabled cycle, LSB-first.
//   clk     : system clock
//   reset   : synchronous active-high reset, clears the CRC to 0x00
//   i_clear : clear the CRC to 0x00 (wins over i_en)
//   i_en    : fold i_bit into the CRC this cycle
//   i_bit   : data bit
//   o_crc   : current CRC register
module crc8_maxim
    import owp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[0] ^ i_bit;
        if (i_clear) begin
            crc_d = 8'h00;
        end else if (i_en) begin
            crc_d = (crc_q >> 1) ^ (fb ? CRC8_POLY_REFL : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/s2p.sv
// Serial-to-parallel receiver: collects WIDTH LSB-first bits, one per strobe,
// checks CRC-8 over them and reports completion or an inter-bit timeout.
//   clk, reset   : clock and synchronous active-high reset
//   i_start      : arm one WIDTH-bit transfer (ignored while busy)
//   i_serial_in  : sampled bus bit, valid with i_bit_strobe
//   i_bit_strobe : capture i_serial_in this cycle
//   o_parallel   : last completed word, bit 0 = first bit received
//   o_busy       : transfer in progress
//   o_done       : one-cycle pulse after the last bit is captured
//   o_crc_ok     : CRC residue of the last completed word was zero
//   o_timeout    : one-cycle pulse when a transfer is abandoned
module s2p
    import owp_pkg::*;
#(
    parameter int unsigned WIDTH   = ROM_ID_WIDTH,
    parameter int unsigned TIMEOUT = 140
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_serial_in,
    input  logic             i_bit_strobe,
    output logic [WIDTH-1:0] o_parallel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_crc_ok,
    output logic             o_timeout
);

    localparam int unsigned       TimerW    = $clog2(TIMEOUT + 1);
    localparam logic [6:0]        LastIdx   = 7'(WIDTH - 1);
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT);

    s2p_state_t        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  par_q, par_d;
    logic [WIDTH-1:0]  shreg_shift;
    logic [6:0]        cnt_q, cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              crc_ok_q, crc_ok_d;
    logic              crc_clear, crc_en;
    logic [7:0]        crc;

    crc8_maxim u_crc (
        .clk     (clk),
        .reset   (reset),
        .i_clear (crc_clear),
        .i_en    (crc_en),
        .i_bit   (i_serial_in),
        .o_crc   (crc)
    );

    assign shreg_shift = {i_serial_in, shreg_q[WIDTH-1:1]};

    // The CRC register settles on the same edge that raises o_done, so the
    // verdict is taken live during the done cycle and held afterwards.
    assign o_crc_ok   = done_q ? (crc == 8'h00) : crc_ok_q;
    assign o_parallel = par_q;
    assign o_busy     = (state_q == RECEIVE);
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        crc_ok_d  = o_crc_ok;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = RECEIVE;
                    shreg_d   = '0;
                    cnt_d     = 7'd0;
                    timer_d   = TimerLoad;
                    crc_clear = 1'b1;
                end
            end
            RECEIVE: begin
                if (i_bit_strobe) begin
                    shreg_d = shreg_shift;
                    crc_en  = 1'b1;
                    cnt_d   = cnt_q + 7'd1;
                    timer_d = TimerLoad;
                    if (cnt_q == LastIdx) begin
                        par_d   = shreg_shift;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_q     <= '0;
            cnt_q     <= 7'd0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            crc_ok_q  <= crc_ok_d;
        end
    end

endmodule

// File: tb/tb_s2p.sv
// Directed bench for s2p with hand-computed expected words.
module tb_s2p;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned TIMEOUT = 140;

    localparam logic [63:0] ROM_GOOD = 64'hA200_0000_01B8_1C02;
    localparam logic [63:0] ROM_BAD  = 64'hA200_0000_01B8_0C02;  // bit 12 flipped
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PATTERN  = 64'h0123_4567_89AB_CDEF;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_serial_in;
    logic             i_bit_strobe;
    logic [WIDTH-1:0] o_parallel;
    logic             o_busy;
    logic             o_done;
    logic             o_crc_ok;
    logic             o_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_to     = 0;
    int both_seen = 0;

    s2p #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_serial_in  (i_serial_in),
        .i_bit_strobe (i_bit_strobe),
        .o_parallel   (o_parallel),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_crc_ok     (o_crc_ok),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_done)              n_done++;
        if (o_timeout)           n_to++;
        if (o_done && o_timeout) both_seen = 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Sends n bits of w LSB-first, one strobe every gap cycles; returns just
    // after the edge that captured the last bit.
    task automatic send_bits(input logic [63:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap - 1) tick();
            i_bit_strobe = 1'b1;
            i_serial_in  = w[i];
            tick();
            i_bit_strobe = 1'b0;
            i_serial_in  = 1'b0;
        end
    endtask

    task automatic send_range(input logic [63:0] w, input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            repeat (gap - 1) tick();
            i_bit_strobe = 1'b1;
            i_serial_in  = w[i];
            tick();
            i_bit_strobe = 1'b0;
            i_serial_in  = 1'b0;
        end
    endtask

    initial begin
        int base;
        int n;

        reset        = 1'b1;
        i_start      = 1'b0;
        i_serial_in  = 1'b0;
        i_bit_strobe = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_parallel", o_parallel, 64'd0);
        check("rst_busy",     o_busy,     64'd0);
        check("rst_done",     o_done,     64'd0);
        check("rst_crc_ok",   o_crc_ok,   64'd0);
        check("rst_timeout",  o_timeout,  64'd0);

        // Strobes while idle change nothing.
        send_bits(ONES, 5, 2);
        tick();
        check("idle_busy",     o_busy,     64'd0);
        check("idle_parallel", o_parallel, 64'd0);
        check("idle_done_cnt", n_done,     64'd0);

        // Good ROM ID at bus timing.
        start();
        check("rom_busy", o_busy, 64'd1);
        send_bits(ROM_GOOD, 64, 71);
        check("rom_done",     o_done,     64'd1);
        check("rom_parallel", o_parallel, ROM_GOOD);
        check("rom_crc_ok",   o_crc_ok,   64'd1);
        check("rom_timeout",  o_timeout,  64'd0);
        tick();
        check("rom_done_end", o_done,   64'd0);
        check("rom_busy_end", o_busy,   64'd0);
        check("rom_crc_hold", o_crc_ok, 64'd1);

        // Single flipped bit must fail the CRC.
        start();
        send_bits(ROM_BAD, 64, 71);
        check("bad_done",     o_done,     64'd1);
        check("bad_parallel", o_parallel, ROM_BAD);
        check("bad_crc_ok",   o_crc_ok,   64'd0);
        tick();

        // Timeout after 10 strobes.
        base = n_done;
        start();
        send_bits(ONES, 10, 3);
        n = 0;
        while (!o_timeout && n < 400) begin
            tick();
            n++;
        end
        check("to_latency",  n,          TIMEOUT + 1);
        check("to_pulse",    o_timeout,  64'd1);
        check("to_no_done",  o_done,     64'd0);
        check("to_parallel", o_parallel, ROM_BAD);
        check("to_crc_ok",   o_crc_ok,   64'd0);
        tick();
        check("to_pulse_end", o_timeout,      64'd0);
        check("to_busy_end",  o_busy,         64'd0);
        check("to_done_cnt",  n_done - base,  64'd0);

        // i_start mid-transfer is ignored.
        start();
        send_bits(ONES, 20, 5);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("midstart_busy", o_busy, 64'd1);
        send_range(ONES, 20, 64, 5);
        check("midstart_done",     o_done,     64'd1);
        check("midstart_parallel", o_parallel, ONES);
        tick();

        // Strobe coincident with i_start is not captured.
        i_start      = 1'b1;
        i_bit_strobe = 1'b1;
        i_serial_in  = 1'b1;
        tick();
        i_start      = 1'b0;
        i_bit_strobe = 1'b0;
        i_serial_in  = 1'b0;
        send_bits(PATTERN, 64, 2);
        check("coinc_done",     o_done,     64'd1);
        check("coinc_parallel", o_parallel, PATTERN);
        tick();

        // Reset mid-transfer clears everything without pulses.
        base = n_to;
        n    = n_done;
        start();
        send_bits(ONES, 30, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_parallel", o_parallel, 64'd0);
        check("mrst_busy",     o_busy,     64'd0);
        check("mrst_done",     o_done,     64'd0);
        check("mrst_crc_ok",   o_crc_ok,   64'd0);
        check("mrst_timeout",  o_timeout,  64'd0);
        repeat (200) tick();
        check("mrst_no_to",   n_to - base,  64'd0);
        check("mrst_no_done", n_done - n,   64'd0);
        start();
        send_bits(64'd0, 64, 2);
        check("zero_done",     o_done,     64'd1);
        check("zero_parallel", o_parallel, 64'd0);
        check("zero_crc_ok",   o_crc_ok,   64'd1);
        tick();

        // Back-to-back: restart in the done cycle.
        base = n_done;
        start();
        send_bits(ROM_GOOD, 64, 3);
        check("b2b_done1",   o_done,     64'd1);
        check("b2b_par1",    o_parallel, ROM_GOOD);
        check("b2b_crc1",    o_crc_ok,   64'd1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("b2b_busy",    o_busy,     64'd1);
        send_bits(PATTERN, 64, 3);
        check("b2b_done2",   o_done,     64'd1);
        check("b2b_par2",    o_parallel, PATTERN);
        tick();
        tick();
        check("b2b_done_cnt", n_done - base, 64'd2);

        check("done_timeout_excl", both_seen, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
